// File: rtl/dataflow_pipe.sv
// dataflow_pipe: pipelined bitwise op unit with valid/ready elastic stages and a completed-transaction counter
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b/op operand side;
// out_valid/out_ready/res/flag result side; txn_cnt counts output handshakes.
// Build option DATAFLOW_PIPE_PARITY_EN adds output par = ^res, pipelined with res.
module dataflow_pipe #(
  parameter int W     = 8,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     res,
  output logic             flag,
  output logic [CNT_W-1:0] txn_cnt
`ifdef DATAFLOW_PIPE_PARITY_EN
  ,
  output logic             par
`endif
);
  logic [LAT-1:0] vld, fl, adv;
  logic [W-1:0]   rs [LAT];
  logic [W-1:0]   cres;
  logic           cflag;
  always_comb begin
    cres  = op == 2'b00 ? a & b : op == 2'b01 ? a | b : op == 2'b10 ? a ^ b : a & ~b;
    cflag = (|(a ^ b)) & (|cres);
  end
  // A stage can load unless it and every stage after it are full while the consumer stalls;
  // written as a reduction rather than a ripple so there is no self-referencing vector.
  for (genvar i = 0; i < LAT; i++) begin : g_adv
    assign adv[i] = out_ready | ~(&vld[LAT-1:i]);
  end
  assign in_ready  = adv[0];
  assign out_valid = vld[LAT-1];
  assign res       = rs[LAT-1];
  assign flag      = fl[LAT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      fl      <= '0;
      txn_cnt <= '0;
      for (int i = 0; i < LAT; i++) rs[i] <= '0;
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          rs[0] <= cres;
          fl[0] <= cflag;
        end
      end
      for (int i = 1; i < LAT; i++)
        if (adv[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            rs[i] <= rs[i-1];
            fl[i] <= fl[i-1];
          end
        end
      if (out_valid && out_ready) txn_cnt <= txn_cnt + 1'b1;
    end
  end
`ifdef DATAFLOW_PIPE_PARITY_EN
  logic [LAT-1:0] pr;
  assign par = pr[LAT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pr <= '0;
    else begin
      if (adv[0] && in_valid) pr[0] <= ^cres;
      for (int i = 1; i < LAT; i++)
        if (adv[i] && vld[i-1]) pr[i] <= pr[i-1];
    end
  end
`endif
endmodule

// File: tb/tb_dataflow_pipe.sv
// tb_dataflow_pipe: directed self-checking bench for dataflow_pipe (W=8, LAT=2, CNT_W=8)
module tb_dataflow_pipe;
  localparam int W = 8, LAT = 2, CNT_W = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0] op = '0;
  logic in_ready, out_valid, flag;
  logic [W-1:0] res;
  logic [CNT_W-1:0] txn_cnt;
`ifdef DATAFLOW_PIPE_PARITY_EN
  logic par;
`endif
  int errs = 0, checks = 0;

  dataflow_pipe #(.W(W), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flag(flag), .txn_cnt(txn_cnt)
`ifdef DATAFLOW_PIPE_PARITY_EN
    , .par(par)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (res !== 8'h00) begin errs++; $display("FAIL reset_res: got %h want 00", res); end
    checks++; if (flag !== 1'b0) begin errs++; $display("FAIL reset_flag: got %b want 0", flag); end
    checks++; if (txn_cnt !== 8'd0) begin errs++; $display("FAIL reset_txn_cnt: got %0d want 0", txn_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    a = 8'hF0; b = 8'h3C; op = 2'b00; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (res !== 8'h30) begin errs++; $display("FAIL basic_res: got %h want 30", res); end
    checks++; if (flag !== 1'b1) begin errs++; $display("FAIL basic_flag: got %b want 1", flag); end
    checks++; if (txn_cnt !== 8'd0) begin errs++; $display("FAIL basic_cnt_before: got %0d want 0", txn_cnt); end
    tick;
    checks++; if (txn_cnt !== 8'd1) begin errs++; $display("FAIL basic_cnt_after: got %0d want 1", txn_cnt); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_res [3];
    exp_res[0] = 8'hAF; exp_res[1] = 8'hAA; exp_res[2] = 8'hA0;
    a = 8'hA5; b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      in_valid = i < 3;
      op = 2'(i + 1);
      #1;
      if (i < 3) begin
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      end
      tick;
      if (i >= 1 && i <= 3) begin
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
        checks++; if (res !== exp_res[i-1]) begin errs++; $display("FAIL b2b_res[%0d]: got %h want %h", i, res, exp_res[i-1]); end
      end
      if (i == 4) begin
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
      end
    end
    checks++; if (txn_cnt !== 8'd4) begin errs++; $display("FAIL b2b_cnt: got %0d want 4", txn_cnt); end
  endtask

  task automatic test_flag_edges;
    a = 8'h55; b = 8'h55; op = 2'b10; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (res !== 8'h00) begin errs++; $display("FAIL xor_same_res: got %h want 00", res); end
    checks++; if (flag !== 1'b0) begin errs++; $display("FAIL xor_same_flag: got %b want 0", flag); end
    a = 8'h01; b = 8'h00; op = 2'b11; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (res !== 8'h01) begin errs++; $display("FAIL andn_res: got %h want 01", res); end
    checks++; if (flag !== 1'b1) begin errs++; $display("FAIL andn_flag: got %b want 1", flag); end
    tick;
    checks++; if (txn_cnt !== 8'd6) begin errs++; $display("FAIL flag_cnt: got %0d want 6", txn_cnt); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'h11; op = 2'b00;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_ready0: got %b want 1", in_ready); end
    tick;
    b = 8'h22;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_ready1: got %b want 1", in_ready); end
    tick;
    b = 8'h33;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL stall_full: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall_valid: got %b want 1", out_valid); end
    checks++; if (res !== 8'h11) begin errs++; $display("FAIL stall_res0: got %h want 11", res); end
    tick;
    tick;
    checks++; if (res !== 8'h11) begin errs++; $display("FAIL stall_hold_res: got %h want 11", res); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL stall_hold_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (res !== 8'h22) begin errs++; $display("FAIL stall_out2: got %h want 22", res); end
    tick;
    checks++; if (res !== 8'h33 || out_valid !== 1'b1) begin errs++; $display("FAIL stall_out3: got %h/%b want 33/1", res, out_valid); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stall_drained: got %b want 0", out_valid); end
    checks++; if (txn_cnt !== 8'd9) begin errs++; $display("FAIL stall_cnt: got %0d want 9", txn_cnt); end
  endtask

  task automatic test_wrap;
    a = 8'h0F; b = 8'hF0; op = 2'b01; in_valid = 1'b1;
    repeat (246) tick;
    in_valid = 1'b0;
    tick;
    tick;
    checks++; if (txn_cnt !== 8'd255) begin errs++; $display("FAIL wrap_max: got %0d want 255", txn_cnt); end
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    checks++; if (txn_cnt !== 8'd0) begin errs++; $display("FAIL wrap_zero: got %0d want 0", txn_cnt); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL wrap_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    a = 8'hF0; b = 8'h0F; op = 2'b01; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    out_ready = 1'b0; in_valid = 1'b1;
    tick;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || txn_cnt !== 8'd1) begin errs++; $display("FAIL rstmid_pre: got %b/%0d want 1/1", out_valid, txn_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    checks++; if (txn_cnt !== 8'd0) begin errs++; $display("FAIL rstmid_cnt: got %0d want 0", txn_cnt); end
    checks++; if (res !== 8'h00) begin errs++; $display("FAIL rstmid_res: got %h want 00", res); end
    tick;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_stale[%0d]: got %b want 0", i, out_valid); end
    end
    checks++; if (txn_cnt !== 8'd0) begin errs++; $display("FAIL rstmid_cnt_after: got %0d want 0", txn_cnt); end
  endtask

`ifdef DATAFLOW_PIPE_PARITY_EN
  task automatic test_parity;
    a = 8'h07; b = 8'h00; op = 2'b01; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (res !== 8'h07 || par !== 1'b1) begin errs++; $display("FAIL par_odd: got %h/%b want 07/1", res, par); end
    a = 8'h03;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (res !== 8'h03 || par !== 1'b0) begin errs++; $display("FAIL par_even: got %h/%b want 03/0", res, par); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_flag_edges;
    test_stall;
    test_wrap;
    test_reset_mid;
`ifdef DATAFLOW_PIPE_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
